regs_cmd_arbiter: RTL
=====================

// Module: regs_cmd_arbiter
// PURPOSE
//  Shares the single ctrl_regs command port (cmd/cmd_addr/cmd_data_w/cmd_data_r) among N_INI initiators.
//  Round-robin arbiter with a per-initiator req/gnt handshake, one command per cycle.
//  Drives registered commands to ctrl_regs and routes each read result back to its issuer.
//  Sits in tb/top between the stimulus initiators and ctrl_regs; replaces the direct iniif hookup.
// PARAMETERS
//  N_INI   4   number of initiators (2..8)
//  ADDR_W  8   command address width
//  DATA_W  32  write/read data width
//  RD_LAT  1   cycles from cmd_o=RD on the port to valid cmd_data_i (1..4)
// PORTS
//  clk_i       in   1             clock, all logic on posedge
//  rst_i       in   1             synchronous reset, active-high
//  req_i       in   N_INI         per-initiator request
//  cmd_i       in   2*N_INI       per-initiator cmd (IDLE=00, RD=01, WR=10), slice i = [2i+1:2i]
//  addr_i      in   ADDR_W*N_INI  per-initiator address
//  wdata_i     in   DATA_W*N_INI  per-initiator write data
//  gnt_o       out  N_INI         one-hot grant, combinational, same cycle as winning req
//  rvalid_o    out  N_INI         one-hot read-return strobe
//  rdata_o     out  DATA_W        read data, valid while any rvalid_o bit is set
//  illegal_o   out  1             1-cycle pulse: granted cmd was 2'b11
//  lock_i      in   N_INI         hold-grant request (only with REGS_ARB_LOCK_EN)
//  cmd_o       out  2             to ctrl_regs cmd_i
//  cmd_addr_o  out  ADDR_W        to ctrl_regs cmd_addr_i
//  cmd_data_o  out  DATA_W        to ctrl_regs cmd_data_i
//  cmd_data_i  in   DATA_W        from ctrl_regs cmd_data_o
// BEHAVIOUR
//  - Reset: cmd_o=IDLE, cmd_addr_o=0, cmd_data_o=0, gnt_o=0, rvalid_o=0, rdata_o=0, illegal_o=0.
//    RR pointer last=N_INI-1, so initiator 0 wins first. Read-tag pipe cleared: reads in flight
//    at reset never produce rvalid.
//  - Handshake: initiator holds req_i and its payload stable until it sees gnt_o[i]=1 at a posedge.
//    A cycle with req_i=1 and gnt_o[i]=1 transfers exactly one command.
//  - Arbitration: each cycle, search req_i starting at last+1 (mod N_INI). First hit wins,
//    gnt_o[win]=1, and last<=win. No req means gnt_o=0 and the pointer holds.
//  - Command issue: winner's cmd/addr/wdata registered onto cmd_o/cmd_addr_o/cmd_data_o at the
//    granting edge. Valid on the port for exactly 1 cycle (latency 1).
//  - Cycles with no grant: port driven IDLE/0/0. RD drives cmd_data_o=0.
//    Granted IDLE drives IDLE and consumes the slot.
//  - Illegal cmd 2'b11: granted (so the initiator is not stuck), port stays IDLE, illegal_o=1
//    in the following cycle.
//  - Read return: RD issue pushes one-hot tag into RD_LAT-deep shift pipe. When the tag exits,
//    rvalid_o[tag]=1 and rdata_o=cmd_data_i (registered).
//    RD granted at edge n gives rvalid in cycle n+1+RD_LAT.
//  - Throughput: 1 cmd/cycle. Back-to-back reads return in issue order, one per cycle,
//    with no stall.
//  - Simultaneous: a new grant and a read return in the same cycle are independent.
//    Pointer wrap N_INI-1 -> 0.
//  - Widths: cmd_i/addr_i/wdata_i are flat packed vectors, slice i at [W*(i+1)-1 : W*i].
// CONFIGURATION
//  REGS_ARB_LOCK_EN defined: lock_i port exists. 2-state FSM ARB/LOCKED, reset ARB.
//    ARB -> LOCKED when the winner has lock_i[win]=1, owner<=win.
//    In LOCKED only the owner is eligible; other requests wait.
//    LOCKED -> ARB on an owner grant with lock_i=0, or when req_i[owner]=0. The pointer then
//    continues from owner+1.
//    Reset in LOCKED returns to ARB.
//  Undefined: no lock_i port, no FSM, pure round-robin every cycle.
// TESTING
//  1 ini0 WR addr 0x00 data 0x0000_FFFF -> gnt_o=0001 same cycle. Next cycle cmd_o=10,
//    cmd_addr_o=00, cmd_data_o=0000_FFFF. Cycle after: IDLE.
//  2 ini0..3 hold RD continuously -> gnt_o sequence 0001,0010,0100,1000,0001, one per cycle,
//    no gaps.
//  3 ini2 RD 0x10, then ini1 RD 0x14; model returns 0xA5A5_0010 / 0xA5A5_0014 after RD_LAT ->
//    rvalid_o=0100 then 0010 on consecutive cycles with matching rdata_o.
//  4 ini1 cmd=2'b11 -> gnt_o=0010, illegal_o pulse 1 cycle, cmd_o stays IDLE, ini1 unblocked.
//  5 rst_i=1 for 1 cycle right after ini3 RD grant -> no rvalid ever, port IDLE/0/0,
//    next req from ini0 and ini3 grants ini0.
//  6 (REGS_ARB_LOCK_EN) ini3 lock_i=1 for 3 WRs while ini0 requests -> ini3 granted 3 consecutive
//    cycles (lock_i=0 on the 3rd), then ini0.

Source files
------------

// File: rtl/regs_cmd_arbiter_if.sv
// Initiator-side and ctrl_regs-side signals of the shared command port arbiter.
// lock_i exists only when REGS_ARB_LOCK_EN is defined.
interface regs_cmd_arbiter_if #(
   parameter int N_INI  = 4,
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
);
   logic [N_INI-1:0]        req_i;
   logic [2*N_INI-1:0]      cmd_i;
   logic [ADDR_W*N_INI-1:0] addr_i;
   logic [DATA_W*N_INI-1:0] wdata_i;
   logic [N_INI-1:0]        gnt_o;
   logic [N_INI-1:0]        rvalid_o;
   logic [DATA_W-1:0]       rdata_o;
   logic                    illegal_o;
   logic [1:0]              cmd_o;
   logic [ADDR_W-1:0]       cmd_addr_o;
   logic [DATA_W-1:0]       cmd_data_o;
   logic [DATA_W-1:0]       cmd_data_i;
`ifdef REGS_ARB_LOCK_EN
   logic [N_INI-1:0]        lock_i;

   modport slave (
      input  req_i, cmd_i, addr_i, wdata_i, lock_i, cmd_data_i,
      output gnt_o, rvalid_o, rdata_o, illegal_o, cmd_o, cmd_addr_o, cmd_data_o
   );
   modport master (
      output req_i, cmd_i, addr_i, wdata_i, lock_i, cmd_data_i,
      input  gnt_o, rvalid_o, rdata_o, illegal_o, cmd_o, cmd_addr_o, cmd_data_o
   );
`else
   modport slave (
      input  req_i, cmd_i, addr_i, wdata_i, cmd_data_i,
      output gnt_o, rvalid_o, rdata_o, illegal_o, cmd_o, cmd_addr_o, cmd_data_o
   );
   modport master (
      output req_i, cmd_i, addr_i, wdata_i, cmd_data_i,
      input  gnt_o, rvalid_o, rdata_o, illegal_o, cmd_o, cmd_addr_o, cmd_data_o
   );
`endif
endinterface

// File: rtl/regs_cmd_arbiter.sv
// Round-robin arbiter sharing the ctrl_regs command port among N_INI initiators.
// Optional grant locking is built when REGS_ARB_LOCK_EN is defined:
//   state  | meaning
//   ARB    | plain round-robin among all requesters
//   LOCKED | only the owner is eligible while it keeps requesting
module regs_cmd_arbiter #(
   parameter int N_INI  = 4,
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32,
   parameter int RD_LAT = 1
) (
   input logic               clk_i,
   input logic               rst_i,
   regs_cmd_arbiter_if.slave bus
);
   localparam int IDX_W = $clog2(N_INI);
   localparam logic [1:0] CMD_IDLE = 2'b00;
   localparam logic [1:0] CMD_RD   = 2'b01;
   localparam logic [1:0] CMD_WR   = 2'b10;
   localparam logic [1:0] CMD_ILL  = 2'b11;

   logic [IDX_W-1:0]  last;
   logic [IDX_W-1:0]  win;
   logic              gnt_any;
   logic [N_INI-1:0]  elig;
   logic [N_INI-1:0]  gnt;
   logic [1:0]        win_cmd;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_wdata;
   logic [N_INI-1:0]  issue_tag;
   logic [N_INI-1:0]  tag_pipe [RD_LAT];

`ifdef REGS_ARB_LOCK_EN
   typedef enum logic {ARB, LOCKED} state_t;
   state_t           state;
   logic [IDX_W-1:0] owner;

   // A locked owner that drops its request releases the port in the same cycle.
   always_comb begin
      elig = bus.req_i;
      if (state == LOCKED && bus.req_i[owner]) begin
         elig        = '0;
         elig[owner] = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= ARB;
         owner <= '0;
      end else if (gnt_any) begin
         state <= bus.lock_i[win] ? LOCKED : ARB;
         owner <= win;
      end else begin
         state <= ARB;
      end
   end
`else
   assign elig = bus.req_i;
`endif

   always_comb begin : arb_search
      int idx;
      idx     = 0;
      gnt_any = 1'b0;
      win     = last;
      gnt     = '0;
      for (int off = 1; off <= N_INI; off++) begin
         idx = (int'(last) + off) % N_INI;
         if (!gnt_any && elig[idx]) begin
            gnt_any = 1'b1;
            win     = IDX_W'(idx);
         end
      end
      if (gnt_any) gnt[win] = 1'b1;
   end

   always_comb begin
      win_cmd   = bus.cmd_i[2*win +: 2];
      win_addr  = bus.addr_i[ADDR_W*win +: ADDR_W];
      win_wdata = bus.wdata_i[DATA_W*win +: DATA_W];
   end

   assign bus.gnt_o = gnt;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         last           <= IDX_W'(N_INI-1);
         bus.cmd_o      <= CMD_IDLE;
         bus.cmd_addr_o <= '0;
         bus.cmd_data_o <= '0;
         bus.illegal_o  <= 1'b0;
         bus.rvalid_o   <= '0;
         bus.rdata_o    <= '0;
         issue_tag      <= '0;
         for (int i = 0; i < RD_LAT; i++) tag_pipe[i] <= '0;
      end else begin
         if (gnt_any) last <= win;
         bus.cmd_o      <= CMD_IDLE;
         bus.cmd_addr_o <= '0;
         bus.cmd_data_o <= '0;
         issue_tag      <= '0;
         bus.illegal_o  <= gnt_any && (win_cmd == CMD_ILL);
         if (gnt_any && (win_cmd == CMD_RD || win_cmd == CMD_WR)) begin
            bus.cmd_o      <= win_cmd;
            bus.cmd_addr_o <= win_addr;
            bus.cmd_data_o <= (win_cmd == CMD_WR) ? win_wdata : '0;
         end
         if (gnt_any && win_cmd == CMD_RD) issue_tag <= gnt;
         // issue_tag tracks cmd_o; the pipe then covers ctrl_regs' read latency.
         tag_pipe[0] <= issue_tag;
         for (int i = 1; i < RD_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
         bus.rvalid_o <= tag_pipe[RD_LAT-1];
         bus.rdata_o  <= (|tag_pipe[RD_LAT-1]) ? bus.cmd_data_i : '0;
      end
   end
endmodule
